// File: rtl/dram_stream_dma.sv
// Byte-stream DMA initiator for the 64 KiB data RAM: image load from s_* stream, result dump to m_* stream.
// Optional running byte sum on `checksum` is built only when DMA_CHECKSUM_EN is defined.
module dram_stream_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              load_done,
  output logic              dump_done,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  state_t            state_r;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] rem_r;
  logic [1:0]        occ_r;
  logic [1:0]        inflight_r;
  logic [DATA_W-1:0] fifo1_r;

  logic       ret_s;
  logic       pop_s;
  logic       issue_s;
  logic       ld_hs_s;
  logic       start_acc_s;
  logic [1:0] occ_nxt_s;
  logic [1:0] infl_base_s;

  // Handshakes and dump read-issue decision; m_data register doubles as the FIFO head.
  always_comb begin
    ret_s       = mem_read;
    pop_s       = m_valid & m_ready;
    occ_nxt_s   = occ_r + {1'b0, ret_s} - {1'b0, pop_s};
    infl_base_s = inflight_r - {1'b0, ret_s};
    issue_s     = (state_r == DUMP) && (rem_r != ZERO_A) &&
                  (({1'b0, occ_nxt_s} + {1'b0, infl_base_s}) < 3'd2);
    ld_hs_s     = (state_r == LOAD) && s_valid && s_ready;
    start_acc_s = (state_r == IDLE) && (start_load || start_dump);
  end

  // Transfer FSM with all stream and memory outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      ptr_r      <= ZERO_A;
      rem_r      <= ZERO_A;
      occ_r      <= 2'd0;
      inflight_r <= 2'd0;
      fifo1_r    <= {DATA_W{1'b0}};
      s_ready    <= 1'b0;
      m_data     <= {DATA_W{1'b0}};
      m_valid    <= 1'b0;
      mem_addr   <= ZERO_A;
      mem_write  <= 1'b0;
      mem_read   <= 1'b0;
      mem_wdata  <= {DATA_W{1'b0}};
      busy       <= 1'b0;
      load_done  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      load_done <= 1'b0;
      dump_done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_acc_s) begin
            busy       <= 1'b1;
            occ_r      <= 2'd0;
            inflight_r <= 2'd0;
            m_valid    <= 1'b0;
            ptr_r      <= base_addr;
            rem_r      <= length;
            if (length == ZERO_A) begin
              // Empty transfer: no memory access, just the matching done pulse.
              state_r   <= DONE;
              load_done <= start_load;
              dump_done <= ~start_load;
            end else if (start_load) begin
              state_r <= LOAD;
              s_ready <= 1'b1;
            end else begin
              state_r    <= DUMP;
              mem_read   <= 1'b1;
              mem_addr   <= base_addr;
              ptr_r      <= base_addr + ONE_A;
              rem_r      <= length - ONE_A;
              inflight_r <= 2'd1;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_hs_s) begin
            mem_write <= 1'b1;
            mem_addr  <= ptr_r;
            mem_wdata <= s_data;
            ptr_r     <= ptr_r + ONE_A;
            rem_r     <= rem_r - ONE_A;
            s_ready   <= (rem_r != ONE_A);
          end else if (rem_r == ZERO_A) begin
            state_r   <= DONE;
            load_done <= 1'b1;
          end else begin
            s_ready <= 1'b1;
          end
        end
        DUMP: begin
          occ_r      <= occ_nxt_s;
          m_valid    <= (occ_nxt_s != 2'd0);
          inflight_r <= infl_base_s + {1'b0, issue_s};
          case ({ret_s, pop_s})
            2'b10: begin
              if (occ_r == 2'd0) begin
                m_data <= mem_rdata;
              end else begin
                fifo1_r <= mem_rdata;
              end
            end
            2'b01: begin
              if (occ_r == 2'd2) begin
                m_data <= fifo1_r;
              end else begin
                m_data <= m_data;
              end
            end
            2'b11: begin
              if (occ_r == 2'd2) begin
                m_data  <= fifo1_r;
                fifo1_r <= mem_rdata;
              end else begin
                m_data <= mem_rdata;
              end
            end
            default: begin
              m_data <= m_data;
            end
          endcase
          if (issue_s) begin
            mem_read <= 1'b1;
            mem_addr <= ptr_r;
            ptr_r    <= ptr_r + ONE_A;
            rem_r    <= rem_r - ONE_A;
          end else if ((rem_r == ZERO_A) && (infl_base_s == 2'd0) && (occ_nxt_s == 2'd0)) begin
            state_r   <= DONE;
            dump_done <= 1'b1;
          end else begin
            rem_r <= rem_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          s_ready <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_CHECKSUM_EN
  // Byte sum: load bytes at input handshake, dump bytes at output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= 16'h0000;
    end else if (start_acc_s) begin
      checksum <= 16'h0000;
    end else if (ld_hs_s) begin
      checksum <= checksum + {{(16-DATA_W){1'b0}}, s_data};
    end else if (pop_s) begin
      checksum <= checksum + {{(16-DATA_W){1'b0}}, m_data};
    end else begin
      checksum <= checksum;
    end
  end
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_dram_stream_dma.sv
// Directed bench for dram_stream_dma: scoreboarded RAM writes and output bytes plus timing checks.
module tb_dram_stream_dma;

`ifdef DMA_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_load, start_dump;
  logic [15:0] base_addr, length;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic [15:0] mem_addr;
  logic        mem_write, mem_read;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        busy, load_done, dump_done;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  dram_stream_dma #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
    .base_addr(base_addr), .length(length), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .load_done(load_done), .dump_done(dump_done), .checksum(checksum)
  );

  // RAM model: write on the edge, combinational read so data is sampled at the edge after mem_read.
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) if (mem_write) ram[mem_addr] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [23:0] wr_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  ld_bytes [0:15];
  logic [15:0] ld_ptr;
  int wr_cnt, rd_cnt, pop_cnt, ld_done_cnt, dp_done_cnt;
  int first_wr_cyc, last_wr_cyc, first_pop_cyc, last_pop_cyc, first_valid_cyc;
  int ld_done_cyc, dp_done_cyc, start_cyc;
  logic [15:0] first_wr_addr, last_wr_addr;
  bit fv_armed, prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_write || mem_read) chk("rw_exclusive", 32'(mem_write & mem_read), 32'd0);
      if (mem_write) begin
        wr_cnt++;
        if (wr_cnt == 1) begin first_wr_cyc = cyc; first_wr_addr = mem_addr; end
        last_wr_cyc  = cyc;
        last_wr_addr = mem_addr;
        if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          logic [23:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[23:8]));
          chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
      if (s_valid && s_ready) begin
        wr_q.push_back({ld_ptr, s_data});
        shadow[ld_ptr] = s_data;
        ld_ptr = ld_ptr + 16'h0001;
      end
      if (mem_read) rd_cnt++;
      if (mem_read || m_valid) chk("pending_le2", 32'((rd_cnt - pop_cnt) <= 2), 32'd1);
      if (fv_armed && m_valid) begin first_valid_cyc = cyc; fv_armed = 1'b0; end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        if (pop_cnt == 0) first_pop_cyc = cyc;
        pop_cnt++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
        else chk("out_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (load_done) begin ld_done_cnt++; ld_done_cyc = cyc; end
      if (dump_done) begin dp_done_cnt++; dp_done_cyc = cyc; end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'({load_done, dump_done}), 32'd0);
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
  endtask

  task automatic start_op(input bit ld, input logic [15:0] base, input logic [15:0] len);
    tick();
    wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; fv_armed = 1'b1;
    start_load = ld; start_dump = !ld; base_addr = base; length = len;
    start_cyc = cyc;
    tick();
    start_load = 1'b0; start_dump = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] base, input int len);
    int idx = 0;
    int n = 0;
    bit hs;
    ld_ptr = base;
    s_data = ld_bytes[0]; s_valid = 1'b1;
    start_op(1'b1, base, 16'(len));
    while (idx < len && n < 100) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      tick();
      if (hs) idx++;
      if (idx < len) s_data = ld_bytes[idx];
      n++;
    end
    s_valid = 1'b0;
    chk("load_all_accepted", 32'(idx), 32'(len));
  endtask

  task automatic do_dump(input logic [15:0] base, input int len);
    logic [15:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 16'(i);
      exp_q.push_back(shadow[a]);
    end
    start_op(1'b0, base, 16'(len));
  endtask

  task automatic wait_done(input bit dump, input int budget, input bit toggle, output bit got);
    int n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      if (dump ? dump_done : load_done) got = 1'b1;
      else begin
        tick();
        n++;
        if (toggle) m_ready = (n % 3 == 0);
      end
    end
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int ld_before;
    rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; base_addr = 16'h0000;
    length = 16'h0000; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b1;
    ld_done_cnt = 0; dp_done_cnt = 0; prev_stall = 1'b0; fv_armed = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Load 4 bytes at 0x0100 with s_valid held high.
    ld_bytes[0] = 8'h11; ld_bytes[1] = 8'h22; ld_bytes[2] = 8'h33; ld_bytes[3] = 8'h44;
    do_load(16'h0100, 4);
    wait_done(1'b0, 20, 1'b0, got);
    chk("t1_done_seen", 32'(got), 32'd1);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd4);
    chk("t1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 32'd3);
    chk("t1_done_latency", 32'(ld_done_cyc - last_wr_cyc), 32'd1);
    chk("t1_busy_in_done", 32'(busy), 32'd1);
    chk("t1_checksum", 32'(checksum), CK_EN ? 32'h00AA : 32'h0000);
    chk("t1_wr_q_empty", 32'(wr_q.size()), 32'd0);
    @(negedge clk);
    chk("t1_busy_fall", 32'(busy), 32'd0);
    chk("t1_done_one_cycle", 32'(load_done), 32'd0);

    // Dump the same 4 bytes with m_ready high.
    m_ready = 1'b1;
    do_dump(16'h0100, 4);
    wait_done(1'b1, 20, 1'b0, got);
    chk("t2_done_seen", 32'(got), 32'd1);
    chk("t2_first_valid", 32'(first_valid_cyc - start_cyc), 32'd2);
    chk("t2_pop_cnt", 32'(pop_cnt), 32'd4);
    chk("t2_consecutive", 32'(last_pop_cyc - first_pop_cyc), 32'd3);
    chk("t2_done_latency", 32'(dp_done_cyc - last_pop_cyc), 32'd1);
    chk("t2_checksum", 32'(checksum), CK_EN ? 32'h00AA : 32'h0000);
    chk("t2_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Load 6 random bytes, dump them with m_ready toggling 1,0,0,1,...
    for (int i = 0; i < 6; i++) ld_bytes[i] = 8'($urandom_range(0, 255));
    do_load(16'h0200, 6);
    wait_done(1'b0, 30, 1'b0, got);
    chk("t3_load_done", 32'(got), 32'd1);
    do_dump(16'h0200, 6);
    wait_done(1'b1, 100, 1'b1, got);
    m_ready = 1'b1;
    chk("t3_done_seen", 32'(got), 32'd1);
    chk("t3_pop_cnt", 32'(pop_cnt), 32'd6);
    chk("t3_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of memory, both directions.
    ld_bytes[0] = 8'hA5; ld_bytes[1] = 8'h5A; ld_bytes[2] = 8'hC3;
    do_load(16'hFFFE, 3);
    wait_done(1'b0, 20, 1'b0, got);
    chk("t4_load_done", 32'(got), 32'd1);
    chk("t4_first_addr", 32'(first_wr_addr), 32'h0000FFFE);
    chk("t4_last_addr", 32'(last_wr_addr), 32'h00000000);
    do_dump(16'hFFFE, 3);
    wait_done(1'b1, 20, 1'b0, got);
    chk("t4_dump_done", 32'(got), 32'd1);
    chk("t4_pop_cnt", 32'(pop_cnt), 32'd3);

    // Zero-length dump.
    ld_before = ld_done_cnt;
    do_dump(16'h0100, 0);
    wait_done(1'b1, 5, 1'b0, got);
    chk("t5_done_seen", 32'(got), 32'd1);
    chk("t5_no_read", 32'(rd_cnt), 32'd0);
    chk("t5_done_within2", 32'((dp_done_cyc - start_cyc) <= 2), 32'd1);
    chk("t5_no_load_done", 32'(ld_done_cnt), 32'(ld_before));

    // Reset on the second byte of a 5-byte dump, then a normal load.
    for (int i = 0; i < 5; i++) ld_bytes[i] = 8'(8'h60 + 8'(i));
    do_load(16'h0300, 5);
    wait_done(1'b0, 30, 1'b0, got);
    chk("t6_load_done", 32'(got), 32'd1);
    do_dump(16'h0300, 5);
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (m_valid) got = 1'b1;
    end
    chk("t6_first_valid_seen", 32'(got), 32'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_zero("t6_midreset");
    exp_q.delete();
    wr_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    ld_bytes[0] = 8'h3C; ld_bytes[1] = 8'hC3;
    do_load(16'h0400, 2);
    wait_done(1'b0, 20, 1'b0, got);
    chk("t6_post_load_done", 32'(got), 32'd1);
    chk("t6_post_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t6_post_wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
